// File: rtl/fft_stage_sequencer_pkg.sv
// Shared definitions for the FFT stage sequencer and stage controller.
// State encodings and default frame geometry.
package fft_stage_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

    localparam int DEF_NUMSTAGES = 5;
    localparam int DEF_STAGE_W   = 3;
    localparam int DEF_TIMEOUT   = 64;

    function automatic logic is_busy(seq_state_e s);
        return s != S_IDLE;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_toggle_edge_det.sv
// Toggle-level handshake detector: one pulse per change of d.
// Holds the registered copy of d; reusable for any toggle handshake.
module toggle_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic toggle
);

    logic done_q;
    logic done_d;

    always_comb begin
        done_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign toggle = d ^ done_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Frame-level sequencer stepping the stage controller through all FFT stages.
// Optional per-stage watchdog enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter int NUMSTAGES = DEF_NUMSTAGES,
    parameter int STAGE_W   = DEF_STAGE_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stage_done,
    output logic               stage_en,
    output logic [STAGE_W-1:0] stage_num,
    output logic               busy,
    output logic               frame_done,
    output logic               seq_err
);

    localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUMSTAGES - 1);

    if ((2 ** STAGE_W) < NUMSTAGES || TIMEOUT < 2) begin : g_bad_cfg
        $error("fft_stage_sequencer: bad STAGE_W/NUMSTAGES/TIMEOUT");
    end

    seq_state_e         state_q, state_d;
    logic [STAGE_W-1:0] stage_num_q, stage_num_d;
    logic               toggle;

    toggle_edge_det u_tdet (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (stage_done),
        .toggle (toggle)
    );

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            seq_err_q, seq_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        stage_num_d = stage_num_q;
`ifdef FFT_SEQ_TIMEOUT_EN
        wd_d        = wd_q;
        seq_err_d   = seq_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    stage_num_d = '0;
`ifdef FFT_SEQ_TIMEOUT_EN
                    wd_d        = '0;
`endif
                end
            end
            S_RUN: begin
                if (toggle) begin
                    state_d = (stage_num_q == LAST) ? S_DONE : S_GAP;
`ifdef FFT_SEQ_TIMEOUT_EN
                end else if (wd_q == WD_LAST) begin
                    // stalled stage: abandon the frame, no frame_done
                    state_d     = S_IDLE;
                    stage_num_d = '0;
                    seq_err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            S_GAP: begin
                state_d     = S_RUN;
                stage_num_d = stage_num_q + 1'b1;
`ifdef FFT_SEQ_TIMEOUT_EN
                wd_d        = '0;
`endif
            end
            S_DONE: begin
                state_d     = S_IDLE;
                stage_num_d = '0;
            end
            default: begin
                state_d     = S_IDLE;
                stage_num_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            stage_num_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_num_q <= stage_num_d;
        end
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            seq_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign stage_en   = (state_q == S_RUN);
    assign busy       = is_busy(state_q);
    assign frame_done = (state_q == S_DONE);
    assign stage_num  = stage_num_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: a responder stands in for the stage controller with
// per-stage latencies; an event-time model predicts every output event.
module tb_fft_stage_sequencer;

    localparam int NS = 5;
    localparam int SW = 3;
    localparam int TO = 64;

    localparam int K_STAGE = 0;
    localparam int K_DONE  = 1;
    localparam int K_IDLE  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stage_done = 1'b0;
    logic          stage_en;
    logic [SW-1:0] stage_num;
    logic          busy;
    logic          frame_done;
    logic          seq_err;

    always #5 clk = ~clk;

    fft_stage_sequencer #(
        .NUMSTAGES (NS),
        .STAGE_W   (SW),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stage_done (stage_done),
        .stage_en   (stage_en),
        .stage_num  (stage_num),
        .busy       (busy),
        .frame_done (frame_done),
        .seq_err    (seq_err)
    );

    typedef struct {
        int kind;
        int stg;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  lat_q[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    bit  freeze = 1'b0;
    bit  spur = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] got, logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got %0d exp %0d at cycle %0d", nm, got, expv, cyc);
        end
    endtask

    task automatic got_ev(int kind, int stg, int c);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event kind %0d stage %0d cycle %0d", kind, stg, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.stg != stg || e.cyc != c) begin
                fails++;
                $display("FAIL event got kind %0d stage %0d cycle %0d exp kind %0d stage %0d cycle %0d",
                         kind, stg, c, e.kind, e.stg, e.cyc);
            end
        end
    endtask

    // monitor: turns output transitions into events for the scoreboard
    logic en_p = 1'b0;
    logic busy_p = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            en_p = 1'b0;
            busy_p = 1'b0;
        end else begin
            if (stage_en && !en_p) got_ev(K_STAGE, int'(stage_num), cyc);
            if (frame_done) got_ev(K_DONE, 0, cyc);
            if (busy_p && !busy) begin
                got_ev(K_IDLE, 0, cyc);
                check("idle_stage_num", 32'(stage_num), 0);
            end
            en_p = stage_en;
            busy_p = busy;
        end
    end

    // responder: toggles stage_done after a per-stage number of enabled cycles
    int rcnt = 0;
    int rcur = 9;
    always @(negedge clk) begin
        if (!rst_n) begin
            rcnt = 0;
            stage_done = 1'b0;
        end else if (stage_en) begin
            if (rcnt == 0) rcur = (lat_q.size() > 0) ? lat_q.pop_front() : 9;
            rcnt++;
            if (!freeze && rcnt == rcur) stage_done = ~stage_done;
        end else begin
            rcnt = 0;
            if (spur && $urandom_range(3) == 0) stage_done = ~stage_done;
        end
    end

    // model: stage s runs lat cycles, one gap cycle, DONE right after the last run
    function automatic int push_frame(int e, bit rnd);
        int r = e;
        int d = e;
        int l;
        for (int s = 0; s < NS; s++) begin
            l = rnd ? int'($urandom_range(1, 12)) : 9;
            lat_q.push_back(l);
            exp_q.push_back('{K_STAGE, s, r});
            if (s < NS - 1) r = r + l + 1;
            else d = r + l;
        end
        exp_q.push_back('{K_DONE, 0, d});
        exp_q.push_back('{K_IDLE, 0, d + 1});
        return d;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(busy), 0);
    endtask

    task automatic run_frames(int n, bit rnd);
        int e;
        int last_e;
        int d;
        @(negedge clk);
        e = cyc + 1;
        last_e = e;
        for (int k = 0; k < n; k++) begin
            last_e = e;
            d = push_frame(e, rnd);
            e = d + 2;
        end
        start = 1'b1;
        while (cyc < last_e) @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic check_reset_outs();
        check("rst_stage_en", 32'(stage_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_stage_num", 32'(stage_num), 0);
        check("rst_seq_err", 32'(seq_err), 0);
    endtask

    initial begin
        int e;
        int d;
        repeat (3) @(negedge clk);
        check_reset_outs();
        #2 rst_n = 1'b1;

        // nominal frame, fixed latency
        run_frames(1, 1'b0);
        // start held through two frames
        run_frames(2, 1'b0);

        // random latencies with spurious toggles outside RUN
        spur = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frames(1, 1'b1);
        end
        run_frames(3, 1'b1);

        // reset in the middle of stage 2
        @(negedge clk);
        e = cyc + 1;
        d = push_frame(e, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e + 23) @(negedge clk);
        check("mid_stage_num", 32'(stage_num), 2);
        check("mid_stage_en", 32'(stage_en), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outs();
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_frames(1, 1'b1);

`ifdef FFT_SEQ_TIMEOUT_EN
        // frozen controller: watchdog abandons the frame
        wait_idle();
        @(negedge clk);
        e = cyc + 1;
        lat_q.push_back(9);
        exp_q.push_back('{K_STAGE, 0, e});
        exp_q.push_back('{K_IDLE, 0, e + TO});
        freeze = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("wd_seq_err", 32'(seq_err), 1);
        check("wd_stage_en", 32'(stage_en), 0);
        freeze = 1'b0;
        run_frames(1, 1'b1);
        check("wd_seq_err_sticky", 32'(seq_err), 1);
`else
        // frozen controller: sequencer waits indefinitely
        wait_idle();
        @(negedge clk);
        e = cyc + 1;
        lat_q.push_back(9);
        exp_q.push_back('{K_STAGE, 0, e});
        freeze = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1000) @(negedge clk);
        check("frz_stage_en", 32'(stage_en), 1);
        check("frz_seq_err", 32'(seq_err), 0);
        check("frz_busy", 32'(busy), 1);
        check("frz_stage_num", 32'(stage_num), 0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        freeze = 1'b0;
        run_frames(1, 1'b1);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
